gray_host: RTL
==============

# gray_host

Host-side responder for the LBP engine's pixel-fetch and result-write interfaces. It streams a 128x128 grayscale image into an external gray SRAM and then serves `gray_req` reads from that SRAM with fixed latency. It commits each `lbp_valid` write into an external result SRAM and keeps a running write count and checksum. When the engine raises `finish`, it reports completion to the system.

## Interface

Parameters:
- `IMG_W`, 128, image width in pixels (power of two)
- `IMG_H`, 128, image height in pixels
- `ADDR_W`, 14, pixel address width; equals log2(`IMG_W`*`IMG_H`)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `load_valid`  in  1  image-stream byte valid
- `load_data`  in  8  image-stream pixel, raster order
- `load_ready`  out  1  high only in LOAD state
- `gray_addr`  in  ADDR_W  pixel address from engine
- `gray_req`  in  1  read request from engine
- `gray_ready`  out  1  high only in SERVE state
- `gray_data`  out  8  pixel returned to engine
- `lbp_addr`  in  ADDR_W  result address from engine
- `lbp_valid`  in  1  result write strobe
- `lbp_data`  in  8  result value
- `finish`  in  1  engine completion pulse
- `gm_addr`  out  ADDR_W  gray SRAM address
- `gm_we`  out  1  gray SRAM write enable
- `gm_wdata`  out  8  gray SRAM write data
- `gm_rdata`  in  8  gray SRAM read data; synchronous read with 1-cycle latency
- `lm_addr`  out  ADDR_W  result SRAM address
- `lm_we`  out  1  result SRAM write enable
- `lm_wdata`  out  8  result SRAM write data
- `done`  out  1  sticky completion flag
- `wr_count`  out  ADDR_W+1  accepted result writes
- `checksum`  out  16  modulo-2^16 sum of accepted `lbp_data`
- `border_err`  out  1  sticky flag, present only with the check feature

## Operation

- The FSM has three states: LOAD, SERVE and DONE. Reset enters LOAD.
- **LOAD:**
  - Each cycle with `load_valid` writes `load_data` to the gray SRAM at `gm_addr` = load counter, with `gm_we`=1.
  - The load counter increments on each accepted byte.
  - On the byte at address `IMG_W*IMG_H-1`, the FSM moves to SERVE on the next edge and the counter wraps to 0.
  - `gray_req` and `lbp_valid` are ignored in LOAD.
- **SERVE:**
  - `gray_req` drives `gm_addr` = `gray_addr` combinationally with `gm_we`=0.
  - `gray_data` equals `gm_rdata` in the cycle after the request. It is then held in a register until the next accepted request.
  - Back-to-back requests are allowed: one pixel per cycle, fully pipelined.
  - `lbp_valid` registers a write on `lm_addr`/`lm_wdata`/`lm_we`, increments `wr_count` (saturating at 2^ADDR_W) and adds `lbp_data`, zero-extended, to `checksum`.
  - `finish` moves the FSM to DONE.
  - `load_valid` is ignored in SERVE.
- **DONE:**
  - `done`=1 and `gray_ready`=0.
  - All inputs are ignored; status outputs are frozen.
  - Only `reset` leaves DONE.
- **Simultaneous `lbp_valid` and `finish`:** the write is committed and counted, then the FSM enters DONE.
- **Reset mid-operation:** the FSM returns to LOAD and all counters, status and hold registers clear. SRAM contents are not cleared.

## Timing

- During reset, and in the first cycle after it, every output is 0 except `load_ready`. `load_ready` is 1 from the first cycle after `reset` deasserts.
- **Load:** the `gm_we` pulse is combinational in the same cycle as `load_valid`. `gray_ready` rises in the cycle after the last byte is accepted.
- **Read latency:** request in cycle t gives `gray_data` valid in t+1 and held through the next request's t'+1.
- **Result write:** `lm_we` asserts in t+1 for `lbp_valid` in t. `wr_count` and `checksum` update at the same edge.
- **`done`:** rises the cycle after the accepted `finish`.

## Configuration

- `GRAY_HOST_BORDER_CHECK_EN`
- **Defined:**
  - A write to a border pixel sets sticky `border_err` and is still committed. Border pixels are row 0, row `IMG_H-1`, column 0 and column `IMG_W-1`, decoded from `lbp_addr`.
  - `border_err` resets to 0.
- **Undefined:** the `border_err` port and its logic are absent.

## Structure

- A shared package `gray_host_pkg` holds:
  - the state enum (LOAD/SERVE/DONE)
  - the `IMG_W`/`IMG_H`/`ADDR_W` defaults
  - the pixel count constant `IMG_PIX`
  - the row/column field widths used by the border decode
- One natural sub-module, `gray_host_border_chk`: combinational row/column decode of `lbp_addr` plus the sticky flag. It is instantiated only under the macro.

## Test plan

- **Load:** stream 16384 bytes of value addr[7:0].
  - `gm_we` pulses exactly 16384 times.
  - `gray_ready` is 1 in the cycle after the last byte; `load_ready` is 0 from then.
- **Read:** back-to-back `gray_req` at addresses 0, 129, 16383.
  - `gray_data` = 0x00, 0x81, 0xFF on consecutive cycles.
  - After the last request, `gray_data` holds 0xFF.
- **Result writes:** 3 writes at addresses 129, 130, 131 with data 0xFF, 0x01, 0x10.
  - `wr_count`=3 and `checksum`=0x0110.
  - `lm_we` is high for 3 cycles, each 1 cycle after its `lbp_valid`.
- **Same-cycle finish:** `lbp_valid` and `finish` in the same cycle, followed by `gray_req`.
  - The write is counted.
  - `done`=1 in the next cycle; `gray_ready`=0.
  - No `gm_addr` activity from the later `gray_req`.
- **Reset mid-load:** reset after 100 bytes.
  - `load_ready` is 1 in the first cycle after reset.
  - The next byte is written at `gm_addr`=0.
  - Status registers are 0.
- **Border check (macro defined):** write at `lbp_addr`=127.
  - `border_err`=1 and stays 1.
  - A write at 129 leaves it 1; `wr_count` counts both.

Source files
------------

// File: rtl/gray_host_pkg.sv
// gray_host_pkg: shared definitions for the gray_host responder.
//   - state_e       : top-level FSM states (LOAD / SERVE / DONE)
//   - *_DEF         : default image geometry and pixel address width
//   - IMG_PIX       : number of pixels in the default image
//   - COL_W / ROW_W : column / row field widths of a pixel address,
//                     used by the border decode
package gray_host_pkg;

  localparam int IMG_W_DEF  = 128;
  localparam int IMG_H_DEF  = 128;
  localparam int ADDR_W_DEF = 14;

  localparam int IMG_PIX = IMG_W_DEF * IMG_H_DEF;

  // Raster address = {row, col}; IMG_W is a power of two so the column
  // is simply the low bits.
  localparam int COL_W = $clog2(IMG_W_DEF);
  localparam int ROW_W = ADDR_W_DEF - COL_W;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gray_host_border_chk.sv
// gray_host_border_chk: flags result writes that land on the image border.
// Decodes row/column from the write address combinationally and keeps a
// sticky error flag that is set by any accepted write to row 0, the last
// row, column 0 or the last column.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears the flag)
//   i_wr            : write accepted this cycle
//   i_addr          : raster address of the write
//   o_border_err    : sticky border-write flag
module gray_host_border_chk
  import gray_host_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int COL_BITS = COL_W,
  parameter int ROW_BITS = ROW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_border_err
);

  logic [COL_BITS-1:0] w_col;
  logic [ROW_BITS-1:0] w_row;
  logic                w_is_border;
  logic                r_border_err;

  assign w_col = i_addr[COL_BITS-1:0];
  assign w_row = i_addr[ADDR_W-1:COL_BITS];

  assign w_is_border = (w_row == '0)
                     | (w_row == ROW_BITS'(IMG_H - 1))
                     | (w_col == '0)
                     | (w_col == COL_BITS'(IMG_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_border_err <= 1'b0;
    end else if (i_wr && w_is_border) begin
      r_border_err <= 1'b1;
    end
  end

  assign o_border_err = r_border_err;

endmodule

// File: rtl/gray_host.sv
// gray_host: host-side responder for the LBP engine.
// Streams a raster image into the external gray SRAM (LOAD), then serves
// pixel reads with one-cycle latency and commits result writes into the
// result SRAM while tracking a write count and checksum (SERVE). A finish
// pulse freezes everything in DONE until reset.
// Optional feature macro: GRAY_HOST_BORDER_CHECK_EN adds the sticky
// border_err output (writes to border pixels are still committed).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   load_valid/load_data/load_ready : image byte stream in
//   gray_addr/gray_req/gray_ready/gray_data : engine pixel-read port
//   lbp_addr/lbp_valid/lbp_data     : engine result-write port
//   finish                          : engine completion pulse
//   gm_addr/gm_we/gm_wdata/gm_rdata : gray SRAM (1-cycle synchronous read)
//   lm_addr/lm_we/lm_wdata          : result SRAM
//   done, wr_count, checksum        : status
//   border_err                      : sticky border flag (macro only)
module gray_host
  import gray_host_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_req,
  output logic              gray_ready,
  output logic [7:0]        gray_data,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic              lbp_valid,
  input  logic [7:0]        lbp_data,
  input  logic              finish,
  output logic [ADDR_W-1:0] gm_addr,
  output logic              gm_we,
  output logic [7:0]        gm_wdata,
  input  logic [7:0]        gm_rdata,
  output logic [ADDR_W-1:0] lm_addr,
  output logic              lm_we,
  output logic [7:0]        lm_wdata,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic [15:0]       checksum
`ifdef GRAY_HOST_BORDER_CHECK_EN
  ,
  output logic              border_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W:0]   WR_MAX   = {1'b1, {ADDR_W{1'b0}}};

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_load_cnt;
  logic              r_rd_pend;     // a read was issued last cycle
  logic [7:0]        r_gray_hold;   // last returned pixel
  logic              r_lm_we;
  logic [ADDR_W-1:0] r_lm_addr;
  logic [7:0]        r_lm_wdata;
  logic [ADDR_W:0]   r_wr_count;
  logic [15:0]       r_checksum;

  logic w_load_acc;
  logic w_req_acc;
  logic w_wr_acc;

  assign w_load_acc = (r_state == ST_LOAD)  && load_valid;
  assign w_req_acc  = (r_state == ST_SERVE) && gray_req;
  assign w_wr_acc   = (r_state == ST_SERVE) && lbp_valid;

  // Next state and combinational outputs
  always_comb begin
    w_state_next = r_state;
    load_ready   = 1'b0;
    gray_ready   = 1'b0;
    done         = 1'b0;
    gm_addr      = '0;
    gm_we        = 1'b0;
    gm_wdata     = '0;
    case (r_state)
      ST_LOAD: begin
        load_ready = 1'b1;
        gm_addr    = r_load_cnt;
        if (w_load_acc) begin
          gm_we    = 1'b1;
          gm_wdata = load_data;
          if (r_load_cnt == LAST_PIX) begin
            w_state_next = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        gray_ready = 1'b1;
        if (gray_req) begin
          gm_addr = gray_addr;
        end
        if (finish) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_LOAD;
      r_load_cnt  <= '0;
      r_rd_pend   <= 1'b0;
      r_gray_hold <= '0;
      r_lm_we     <= 1'b0;
      r_lm_addr   <= '0;
      r_lm_wdata  <= '0;
      r_wr_count  <= '0;
      r_checksum  <= '0;
    end else begin
      r_state <= w_state_next;
      // Counter wraps to 0 naturally after the last pixel address.
      if (w_load_acc) begin
        r_load_cnt <= r_load_cnt + ADDR_W'(1);
      end
      r_rd_pend <= w_req_acc;
      if (r_rd_pend) begin
        r_gray_hold <= gm_rdata;
      end
      r_lm_we <= w_wr_acc;
      if (w_wr_acc) begin
        r_lm_addr  <= lbp_addr;
        r_lm_wdata <= lbp_data;
        r_checksum <= r_checksum + {8'h00, lbp_data};
        if (r_wr_count != WR_MAX) begin
          r_wr_count <= r_wr_count + (ADDR_W + 1)'(1);
        end
      end
    end
  end

  // Fresh SRAM data passes straight through in the cycle after a request;
  // otherwise the last returned pixel is held.
  assign gray_data = r_rd_pend ? gm_rdata : r_gray_hold;
  assign lm_we     = r_lm_we;
  assign lm_addr   = r_lm_addr;
  assign lm_wdata  = r_lm_wdata;
  assign wr_count  = r_wr_count;
  assign checksum  = r_checksum;

`ifdef GRAY_HOST_BORDER_CHECK_EN
  gray_host_border_chk #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .ADDR_W   (ADDR_W),
    .COL_BITS ($clog2(IMG_W)),
    .ROW_BITS (ADDR_W - $clog2(IMG_W))
  ) u_border_chk (
    .clk          (clk),
    .reset        (reset),
    .i_wr         (w_wr_acc),
    .i_addr       (lbp_addr),
    .o_border_err (border_err)
  );
`endif

endmodule
